// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES state type, byte indexing helpers and stage FSM states
// Revision: 1.0
// ============================================================================
package aes_pkg;

   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsm_e;

   localparam int unsigned N_LANES = 4;

   // Byte i = s[r][c] with i = 4c + r, byte 0 in the most significant position.
   function automatic logic [3:0] byte_idx(input logic [1:0] r, input logic [1:0] c);
      return {c, r};
   endfunction

   function automatic logic [7:0] get_byte(input state_t s, input logic [3:0] idx);
      state_t sh;
      sh = s << {idx, 3'b000};
      return sh[127:120];
   endfunction

endpackage
`default_nettype wire

// File: rtl/INV_SBOX.sv
`default_nettype none
// ============================================================================
// INV_SBOX : AES inverse S-box byte lookup with a registered (unreset) output
// Revision: 1.0
// ============================================================================
module INV_SBOX (
   input  logic       clk,
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [0:255][7:0] C_INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   always_ff @(posedge clk) begin
      out_byte <= C_INV_SBOX[in_byte];
   end

endmodule
`default_nettype wire

// File: rtl/inv_shift_sub_bytes.sv
`default_nettype none
// ============================================================================
// inv_shift_sub_bytes : InvShiftRows + InvSubBytes, one column per cycle
// Revision: 1.0
// ============================================================================
module inv_shift_sub_bytes
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] IN_DATA,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] OUT_DATA
);

   fsm_e        state_q, state_d;
   logic [1:0]  col_q, col_d;
   state_t      in_buf_q, in_buf_d;
   state_t      out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;

   logic [7:0]  sbox_in  [N_LANES];
   logic [7:0]  sbox_out [N_LANES];
   logic [31:0] col_word;
   logic        wr_en;
   logic [1:0]  wr_col;

   // InvShiftRows is folded into the read: lane r takes s[r][(col - r) mod 4].
   always_comb begin
      for (int r = 0; r < N_LANES; r++) begin
         logic [1:0] src_c;
         src_c      = col_q - 2'(r);
         sbox_in[r] = get_byte(in_buf_q, byte_idx(2'(r), src_c));
      end
   end

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      INV_SBOX u_inv_sbox (
         .clk      (clk),
         .in_byte  (sbox_in[g]),
         .out_byte (sbox_out[g])
      );
   end

   assign col_word = {sbox_out[0], sbox_out[1], sbox_out[2], sbox_out[3]};

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      in_buf_d    = in_buf_q;
      out_valid_d = out_valid_q;
      wr_en       = 1'b0;
      wr_col      = 2'd0;
      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               in_buf_d = IN_DATA;
               col_d    = 2'd0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // The S-box output lags its input by one cycle, hence column col-1.
            wr_en  = (col_q != 2'd0);
            wr_col = col_q - 2'd1;
            col_d  = col_q + 2'd1;
            if (col_q == 2'd3) state_d = DRAIN;
         end
         DRAIN: begin
            wr_en       = 1'b1;
            wr_col      = 2'd3;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (OUT_READY) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_data_d = out_data_q;
      for (int c = 0; c < 4; c++) begin
         if (wr_en && (wr_col == 2'(c))) out_data_d[127-32*c -: 32] = col_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= 2'd0;
         in_buf_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         in_buf_q    <= in_buf_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;

endmodule
`default_nettype wire
